// File: rtl/cache_config_pkg.sv
// Shared cache request types, address field widths and trace command decode helpers.
package cache_config_pkg;

  localparam int TAG_BITS          = 12;
  localparam int INDEX_BITS        = 14;
  localparam int BLOCK_OFFSET_BITS = 6;
  localparam int ADDR_BITS         = TAG_BITS + INDEX_BITS + BLOCK_OFFSET_BITS;

  typedef enum logic [3:0] {
    TC_CPU_RD_D = 4'd0,
    TC_CPU_WR   = 4'd1,
    TC_CPU_RD_I = 4'd2,
    TC_SNP_RD   = 4'd3,
    TC_SNP_WR   = 4'd4,
    TC_SNP_RWIM = 4'd5,
    TC_SNP_INV  = 4'd6,
    TC_RESERVED = 4'd7,
    TC_CLEAR    = 4'd8,
    TC_PRINT    = 4'd9
  } trace_cmd_t;

  typedef enum logic [3:0] {
    CPU_RD_D, CPU_WR, CPU_RD_I, SNP_RD, SNP_WR, SNP_RWIM, SNP_INV, CLEAR, PRINT
  } req_op_t;

  typedef struct packed {
    req_op_t                      op;
    logic [TAG_BITS-1:0]          tag;
    logic [INDEX_BITS-1:0]        index;
    logic [BLOCK_OFFSET_BITS-1:0] offset;
  } cache_req_t;

  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd <= 4'd6) || (cmd == 4'd8) || (cmd == 4'd9);
  endfunction

  function automatic req_op_t cmd_to_op(input logic [3:0] cmd);
    req_op_t op;
    op = CPU_RD_D;
    case (trace_cmd_t'(cmd))
      TC_CPU_WR:   op = CPU_WR;
      TC_CPU_RD_I: op = CPU_RD_I;
      TC_SNP_RD:   op = SNP_RD;
      TC_SNP_WR:   op = SNP_WR;
      TC_SNP_RWIM: op = SNP_RWIM;
      TC_SNP_INV:  op = SNP_INV;
      TC_CLEAR:    op = CLEAR;
      TC_PRINT:    op = PRINT;
      default:     op = CPU_RD_D;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/trace_cmd_decoder_if.sv
// Trace record input and decoded request output handshakes of trace_cmd_decoder.
interface trace_cmd_decoder_if;
  import cache_config_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [3:0]                   in_cmd;
  logic [31:0]                  in_addr;
  logic                         out_valid;
  logic                         out_ready;
  req_op_t                      out_op;
  logic [TAG_BITS-1:0]          out_tag;
  logic [INDEX_BITS-1:0]        out_index;
  logic [BLOCK_OFFSET_BITS-1:0] out_offset;

  modport master (
    output in_valid, in_cmd, in_addr, out_ready,
    input  in_ready, out_valid, out_op, out_tag, out_index, out_offset
  );

  modport slave (
    input  in_valid, in_cmd, in_addr, out_ready,
    output in_ready, out_valid, out_op, out_tag, out_index, out_offset
  );

endinterface

// File: rtl/req_fifo.sv
// In-order request queue; DEPTH must be a power of two so pointers wrap naturally.
module req_fifo
  import cache_config_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cache_req_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  T                 mem [DEPTH];
  logic             do_push, do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trace_cmd_decoder.sv
// Decodes trace records into queued cache requests; illegal codes are dropped and counted.
// Defining TRACE_CMD_STATS_EN adds stat_cpu / stat_snoop / stat_ctrl acceptance counters.
module trace_cmd_decoder
  import cache_config_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trace_cmd_decoder_if.slave   bus,
  output logic                 err_pulse,
  output logic [ERR_W-1:0]     err_count
`ifdef TRACE_CMD_STATS_EN
  ,
  output logic [31:0]          stat_cpu,
  output logic [31:0]          stat_snoop,
  output logic [15:0]          stat_ctrl
`endif
);

  logic       ready_en;
  logic       full, empty;
  logic       accept, legal;
  cache_req_t push_req, pop_req;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign bus.in_ready = ready_en && !full;
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = cmd_legal(bus.in_cmd);

  assign push_req.op     = cmd_to_op(bus.in_cmd);
  assign push_req.tag    = bus.in_addr[BLOCK_OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign push_req.index  = bus.in_addr[BLOCK_OFFSET_BITS +: INDEX_BITS];
  assign push_req.offset = bus.in_addr[0 +: BLOCK_OFFSET_BITS];

  req_fifo #(
    .DEPTH (DEPTH),
    .T     (cache_req_t)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && legal),
    .push_data (push_req),
    .pop       (bus.out_ready),
    .pop_data  (pop_req),
    .full      (full),
    .empty     (empty)
  );

  assign bus.out_valid  = !empty;
  assign bus.out_op     = pop_req.op;
  assign bus.out_tag    = pop_req.tag;
  assign bus.out_index  = pop_req.index;
  assign bus.out_offset = pop_req.offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= accept && !legal;
      if (accept && !legal && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

`ifdef TRACE_CMD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu   <= '0;
      stat_snoop <= '0;
      stat_ctrl  <= '0;
    end else if (accept && legal) begin
      if (bus.in_cmd <= 4'd2)      stat_cpu   <= stat_cpu + 1'b1;
      else if (bus.in_cmd <= 4'd6) stat_snoop <= stat_snoop + 1'b1;
      else                         stat_ctrl  <= stat_ctrl + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_cmd_decoder.sv
// Self-checking bench for trace_cmd_decoder: directed scenarios plus random traffic against a queue model.
module tb_trace_cmd_decoder;
  import cache_config_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ERR_W   = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  typedef struct {
    req_op_t     op;
    logic [11:0] tag;
    logic [13:0] index;
    logic [5:0]  offset;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_cmd_decoder_if bus ();
  trace_cmd_decoder_if bus_sat ();

  logic             err_pulse, err_pulse_sat;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       err_count_sat;
`ifdef TRACE_CMD_STATS_EN
  logic [31:0] stat_cpu, stat_snoop, sat_cpu, sat_snoop;
  logic [15:0] stat_ctrl, sat_ctrl;
`endif

  trace_cmd_decoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef TRACE_CMD_STATS_EN
    ,
    .stat_cpu   (stat_cpu),
    .stat_snoop (stat_snoop),
    .stat_ctrl  (stat_ctrl)
`endif
  );

  trace_cmd_decoder #(.DEPTH(DEPTH), .ERR_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_sat),
    .err_pulse (err_pulse_sat),
    .err_count (err_count_sat)
`ifdef TRACE_CMD_STATS_EN
    ,
    .stat_cpu   (sat_cpu),
    .stat_snoop (sat_snoop),
    .stat_ctrl  (sat_ctrl)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  exp_t        mq[$];
  bit          m_ready_en;
  bit          m_err_pulse;
  int          m_err_count;
  logic [31:0] m_cpu, m_snoop;
  logic [15:0] m_ctrl;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_of(input int cmd, input logic [31:0] addr);
    exp_t e;
    case (cmd)
      0: e.op = CPU_RD_D;
      1: e.op = CPU_WR;
      2: e.op = CPU_RD_I;
      3: e.op = SNP_RD;
      4: e.op = SNP_WR;
      5: e.op = SNP_RWIM;
      6: e.op = SNP_INV;
      8: e.op = CLEAR;
      default: e.op = PRINT;
    endcase
    e.tag    = 12'(addr >> 20);
    e.index  = 14'((addr >> 6) & 32'h3FFF);
    e.offset = 6'(addr & 32'h3F);
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ready_en  = 0;
    m_err_pulse = 0;
    m_err_count = 0;
    m_cpu = 0; m_snoop = 0; m_ctrl = 0;
  endtask

  task automatic check_outputs();
    check_eq("in_ready", bus.in_ready, m_ready_en && (mq.size() < DEPTH));
    check_eq("out_valid", bus.out_valid, mq.size() > 0);
    check_eq("err_pulse", err_pulse, m_err_pulse);
    check_eq("err_count", err_count, m_err_count);
    if (mq.size() > 0) begin
      check_eq("out_op", bus.out_op, mq[0].op);
      check_eq("out_tag", bus.out_tag, mq[0].tag);
      check_eq("out_index", bus.out_index, mq[0].index);
      check_eq("out_offset", bus.out_offset, mq[0].offset);
    end
`ifdef TRACE_CMD_STATS_EN
    check_eq("stat_cpu", stat_cpu, m_cpu);
    check_eq("stat_snoop", stat_snoop, m_snoop);
    check_eq("stat_ctrl", stat_ctrl, m_ctrl);
`endif
  endtask

  // Drive one clock's worth of inputs from a negedge, predict the edge, then check at the next negedge.
  task automatic cycle(input bit v, input int cmd, input logic [31:0] addr, input bit ordy);
    bit acc, leg;
    bus.in_valid  = v;
    bus.in_cmd    = 4'(cmd);
    bus.in_addr   = addr;
    bus.out_ready = ordy;
    acc = v && m_ready_en && (mq.size() < DEPTH);
    leg = (cmd <= 6) || (cmd == 8) || (cmd == 9);
    if ((mq.size() > 0) && ordy) void'(mq.pop_front());
    if (acc && leg) begin
      mq.push_back(expect_of(cmd, addr));
      if (cmd <= 2)      m_cpu++;
      else if (cmd <= 6) m_snoop++;
      else               m_ctrl++;
    end
    m_err_pulse = acc && !leg;
    if (acc && !leg && (m_err_count < ERR_MAX)) m_err_count++;
    m_ready_en = 1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_in_ready", bus.in_ready, 1'b0);
    check_eq("rst_err_count", err_count, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.in_valid = 0; bus.in_cmd = 0; bus.in_addr = 0; bus.out_ready = 0;
    bus_sat.in_valid = 0; bus_sat.in_cmd = 0; bus_sat.in_addr = 0; bus_sat.out_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("init_out_valid", bus.out_valid, 1'b0);
    check_eq("init_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 1);

    // Saturating error counter on the narrow instance
    for (int i = 0; i < 5; i++) begin
      bus_sat.in_valid = 1'b1;
      bus_sat.in_cmd   = (i % 2 == 0) ? 4'd7 : 4'd12;
      cycle(0, 0, 0, 1);
    end
    bus_sat.in_valid = 1'b0;
    cycle(0, 0, 0, 1);
    check_eq("sat_err_count", err_count_sat, 2'd3);
    check_eq("sat_out_valid", bus_sat.out_valid, 1'b0);
    check_eq("sat_err_pulse", err_pulse_sat, 1'b0);

    // Single record latency
    cycle(1, 0, 32'h12345678, 1);
    check_eq("lat_op", bus.out_op, CPU_RD_D);
    check_eq("lat_tag", bus.out_tag, 12'h123);
    check_eq("lat_index", bus.out_index, 14'h1159);
    check_eq("lat_offset", bus.out_offset, 6'h38);
    cycle(0, 0, 0, 1);

    // Illegal commands are accepted but only counted
    cycle(1, 7, $urandom, 1);
    cycle(1, 15, $urandom, 1);
    cycle(0, 0, 0, 1);
    check_eq("illegal_count", err_count, 2);

    // Full queue, including a refused push while popping
    for (int i = 0; i < DEPTH; i++) cycle(1, i, $urandom, 0);
    check_eq("full_in_ready", bus.in_ready, 1'b0);
    cycle(1, 3, $urandom, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1);
    check_eq("drained_in_ready", bus.in_ready, 1'b1);

    // Ordering across control commands with a random consumer
    cycle(1, 1, $urandom, $urandom_range(0, 1));
    cycle(1, 8, $urandom, $urandom_range(0, 1));
    cycle(1, 9, $urandom, $urandom_range(0, 1));
    cycle(1, 4, $urandom, $urandom_range(0, 1));
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, $urandom_range(0, 1));
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1);

    // Mid-stream reset with three entries queued
    do_reset();
    cycle(0, 0, 0, 0);
    cycle(1, 0, $urandom, 0);
    cycle(1, 2, $urandom, 0);
    cycle(1, 5, $urandom, 0);
`ifdef TRACE_CMD_STATS_EN
    check_eq("stats_cpu2", stat_cpu, 2);
    check_eq("stats_snoop1", stat_snoop, 1);
`endif
    do_reset();
    cycle(0, 0, 0, 1);
    check_eq("post_rst_empty", bus.out_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
